// File: rtl/ddr_mst_pkg.sv
// rtl/ddr_mst_pkg.sv - shared command codes, beat count and FSM encoding for the DDR burst master
package ddr_mst_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // 2:1 controller mode: every app command carries two data beats
  localparam int BEATS_PER_CMD = 2;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_ARB,
    S_WR_CMD,
    S_WR_BEAT2,
    S_RD_CMD,
    S_RD_GAP
  } state_t;

endpackage

// File: rtl/ddr_rd_tracker.sv
// rtl/ddr_rd_tracker.sv - read-return stage: outstanding-beat count, done detection, data register
module ddr_rd_tracker
  import ddr_mst_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int CNT_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_acc,
  input  logic              i_busy,
  input  logic              i_all_issued,
  input  logic [DATA_W-1:0] i_app_rd_data,
  input  logic              i_app_rd_data_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_data_valid,
  output logic              o_done
);

  logic [CNT_W-1:0]  r_outstanding;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_data_valid;
  logic              r_err_unexp;
  logic              w_expected;
  logic [CNT_W-1:0]  w_inc;
  logic [CNT_W-1:0]  w_dec;

  // A beat with nothing outstanding is forwarded but must not underflow the count
  assign w_expected = i_app_rd_data_valid && (r_outstanding != '0);
  assign w_inc      = i_cmd_acc ? CNT_W'(BEATS_PER_CMD) : '0;
  assign w_dec      = w_expected ? CNT_W'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding   <= '0;
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
      r_err_unexp     <= 1'b0;
    end else begin
      r_outstanding   <= r_outstanding + w_inc - w_dec;
      r_rd_data       <= i_app_rd_data;
      r_rd_data_valid <= i_app_rd_data_valid;
      if (i_app_rd_data_valid && (r_outstanding == '0))
        r_err_unexp <= 1'b1;
    end
  end

  assign o_rd_data       = r_rd_data;
  assign o_rd_data_valid = r_rd_data_valid;
  assign o_done          = i_busy && i_all_issued && (r_outstanding == '0);

endmodule

// File: rtl/ddr_burst_master.sv
// rtl/ddr_burst_master.sv - arbitrates block write/read jobs onto the 2:1 DDR app interface
module ddr_burst_master
  import ddr_mst_pkg::*;
#(
  parameter int ADDR_W    = 29,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 16,
  parameter int ADDR_STEP = 8,
  parameter int INIT_TO   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              phy_init_done,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [DATA_W-1:0] wr_fifo_rdata,
  input  logic [9:0]        wr_fifo_cnt,
  output logic              wr_fifo_rd_en,
  output logic              wr_busy,
  output logic              wr_done,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_busy,
  output logic              rd_done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  output logic [DATA_W-1:0] app_wdf_data,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t            r_state;
  state_t            w_next;
  logic              r_wr_busy;
  logic              r_rd_busy;
  logic              r_last_wr;
  logic              r_init_timeout;
  logic [31:0]       r_init_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LEN_W-1:0]  r_wr_len;
  logic [LEN_W-1:0]  r_rd_len;

  logic w_wr_launch;
  logic w_rd_launch;
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_wr_step;
  logic w_rd_step;
  logic w_rd_acc;
  logic w_rd_done;

  assign w_wr_launch = wr_start && !r_wr_busy && (wr_len != '0);
  assign w_rd_launch = rd_start && !r_rd_busy && (rd_len != '0);
  // A write command needs both of its beats already sitting in the FIFO
  assign w_wr_ok     = r_wr_busy && (wr_fifo_cnt >= 10'd2);
  assign w_rd_ok     = (r_rd_len != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    app_en        = 1'b0;
    app_cmd       = CMD_RD;
    app_addr      = '0;
    app_wdf_data  = '0;
    wr_fifo_rd_en = 1'b0;
    w_wr_step     = 1'b0;
    w_rd_step     = 1'b0;
    w_rd_acc      = 1'b0;
    case (r_state)
      S_WAIT_INIT: begin
        if (phy_init_done) w_next = S_ARB;
      end
      S_ARB: begin
        if (w_wr_ok && w_rd_ok) w_next = r_last_wr ? S_RD_CMD : S_WR_CMD;
        else if (w_wr_ok)       w_next = S_WR_CMD;
        else if (w_rd_ok)       w_next = S_RD_CMD;
      end
      S_WR_CMD: begin
        app_en       = 1'b1;
        app_cmd      = CMD_WR;
        app_addr     = r_wr_addr;
        app_wdf_data = wr_fifo_rdata;
        if (app_rdy && app_wdf_rdy) begin
          wr_fifo_rd_en = 1'b1;
          w_next        = S_WR_BEAT2;
        end
      end
      S_WR_BEAT2: begin
        app_cmd      = CMD_WR;
        app_wdf_data = wr_fifo_rdata;
        if (app_wdf_rdy) begin
          wr_fifo_rd_en = 1'b1;
          w_wr_step     = 1'b1;
          w_next        = S_ARB;
        end
      end
      S_RD_CMD: begin
        app_en   = 1'b1;
        app_addr = r_rd_addr;
        if (app_rdy) begin
          w_rd_acc = 1'b1;
          w_next   = S_RD_GAP;
        end
      end
      S_RD_GAP: begin
        w_rd_step = 1'b1;
        w_next    = S_ARB;
      end
      default: w_next = S_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_wr <= 1'b0;
    end else if (r_state == S_ARB) begin
      if (w_next == S_WR_CMD)      r_last_wr <= 1'b1;
      else if (w_next == S_RD_CMD) r_last_wr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_busy <= 1'b0;
      r_wr_addr <= '0;
      r_wr_len  <= '0;
    end else if (w_wr_launch) begin
      r_wr_busy <= 1'b1;
      r_wr_addr <= wr_addr;
      r_wr_len  <= wr_len;
    end else if (w_wr_step) begin
      r_wr_len  <= r_wr_len - LEN_W'(1);
      r_wr_addr <= r_wr_addr + STEP;
      if (r_wr_len == LEN_W'(1)) r_wr_busy <= 1'b0;
    end
  end

  // Read busy outlives the command phase until every returned beat is delivered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_busy <= 1'b0;
      r_rd_addr <= '0;
      r_rd_len  <= '0;
    end else if (w_rd_launch) begin
      r_rd_busy <= 1'b1;
      r_rd_addr <= rd_addr;
      r_rd_len  <= rd_len;
    end else begin
      if (w_rd_step) begin
        r_rd_len  <= r_rd_len - LEN_W'(1);
        r_rd_addr <= r_rd_addr + STEP;
      end
      if (w_rd_done) r_rd_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cnt     <= '0;
      r_init_timeout <= 1'b0;
    end else if ((INIT_TO != 0) && (r_state == S_WAIT_INIT) && !phy_init_done && !r_init_timeout) begin
      r_init_cnt <= r_init_cnt + 32'd1;
      if (r_init_cnt == 32'(INIT_TO - 1)) r_init_timeout <= 1'b1;
    end
  end

  ddr_rd_tracker #(
    .DATA_W(DATA_W),
    .CNT_W (LEN_W + 2)
  ) u_rd_tracker (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_cmd_acc          (w_rd_acc),
    .i_busy             (r_rd_busy),
    .i_all_issued       (r_rd_len == '0),
    .i_app_rd_data      (app_rd_data),
    .i_app_rd_data_valid(app_rd_data_valid),
    .o_rd_data          (rd_data),
    .o_rd_data_valid    (rd_data_valid),
    .o_done             (w_rd_done)
  );

  assign wr_busy = r_wr_busy;
  assign wr_done = w_wr_step && (r_wr_len == LEN_W'(1));
  assign rd_busy = r_rd_busy;
  assign rd_done = w_rd_done;

endmodule

// File: tb/tb_ddr_burst_master.sv
// tb/tb_ddr_burst_master.sv - scoreboard bench for ddr_burst_master with FIFO and memory models
module tb_ddr_burst_master;
  import ddr_mst_pkg::*;

  localparam int ADDR_W = 29;
  localparam int DATA_W = 256;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              phy_init_done = 1'b0;
  logic              wr_start = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [LEN_W-1:0]  wr_len = '0;
  logic [DATA_W-1:0] wr_fifo_rdata = '0;
  logic [9:0]        wr_fifo_cnt = '0;
  logic              wr_fifo_rd_en;
  logic              wr_busy;
  logic              wr_done;
  logic              rd_start = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [LEN_W-1:0]  rd_len = '0;
  logic              rd_busy;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_rdy = 1'b1;
  logic              app_wdf_rdy = 1'b1;
  logic [DATA_W-1:0] app_rd_data = '0;
  logic              app_rd_data_valid = 1'b0;

  ddr_burst_master dut (
    .clk(clk), .rst_n(rst_n), .phy_init_done(phy_init_done),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_fifo_rdata(wr_fifo_rdata), .wr_fifo_cnt(wr_fifo_cnt), .wr_fifo_rd_en(wr_fifo_rd_en),
    .wr_busy(wr_busy), .wr_done(wr_done),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_data(app_wdf_data),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
  } exp_cmd_t;

  exp_cmd_t          exp_cmd_q[$];
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_rd_q[$];
  logic [DATA_W-1:0] ret_q[$];
  logic [DATA_W-1:0] mem0[logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] mem1[logic [ADDR_W-1:0]];

  int errors = 0;
  int checks = 0;
  int wr_done_cnt = 0;
  int rd_done_cnt = 0;
  int rd_beat_cnt = 0;
  int beats_at_done = 0;
  int pop_cnt = 0;
  int en_cnt = 0;
  logic              inject = 1'b0;
  logic [DATA_W-1:0] inject_data = '0;

  function automatic logic [DATA_W-1:0] pat(input int j);
    return {8{32'(32'hA500_0000 + j)}};
  endfunction

  task automatic fifo_refresh();
    wr_fifo_cnt   = 10'(fifo_q.size());
    wr_fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_cmd(input logic [2:0] c, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
    exp_cmd_t e;
    e.cmd = c; e.addr = a; e.d0 = d0; e.d1 = d1;
    exp_cmd_q.push_back(e);
  endtask

  task automatic start_wr(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    @(posedge clk); #1;
    wr_addr = a; wr_len = l; wr_start = 1'b1;
    @(posedge clk); #1;
    wr_start = 1'b0;
  endtask

  task automatic start_rd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    @(posedge clk); #1;
    rd_addr = a; rd_len = l; rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic clear_models();
    fifo_q.delete(); exp_cmd_q.delete(); exp_rd_q.delete(); ret_q.delete();
    fifo_refresh();
    app_rd_data_valid = 1'b0;
    wr_done_cnt = 0; rd_done_cnt = 0; rd_beat_cnt = 0; pop_cnt = 0;
  endtask

  // Controller/FIFO model: sample handshakes at negedge, apply their effect just after posedge
  initial begin : monitor
    exp_cmd_t          cur;
    exp_cmd_t          cur_wr;
    logic [ADDR_W-1:0] cur_addr;
    logic              pop;
    logic              acc_rd;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] b1;
    cur_addr = '0; b0 = '0; b1 = '0;
    forever begin
      @(negedge clk);
      pop = 1'b0; acc_rd = 1'b0;
      if (app_en) en_cnt++;
      if (rst_n && app_en && app_rdy && (app_cmd != CMD_WR || app_wdf_rdy)) begin
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got cmd=%0d addr=%h, required no command", app_cmd, app_addr);
        end else begin
          cur = exp_cmd_q.pop_front();
          checks++;
          if (app_cmd !== cur.cmd || app_addr !== cur.addr) begin
            errors++;
            $display("FAIL cmd_order: got cmd=%0d addr=%h, required cmd=%0d addr=%h",
                     app_cmd, app_addr, cur.cmd, cur.addr);
          end
          if (cur.cmd == CMD_WR) begin
            checks++;
            if (app_wdf_data !== cur.d0 || wr_fifo_rd_en !== 1'b1) begin
              errors++;
              $display("FAIL wr_beat1: got data=%h pop=%b, required data=%h pop=1",
                       app_wdf_data[31:0], wr_fifo_rd_en, cur.d0[31:0]);
            end
            mem0[app_addr] = app_wdf_data;
            cur_addr = app_addr;
            cur_wr = cur;
          end else begin
            acc_rd = 1'b1;
            b0 = mem0.exists(app_addr) ? mem0[app_addr] : '0;
            b1 = mem1.exists(app_addr) ? mem1[app_addr] : '0;
          end
        end
      end
      if (rst_n && wr_fifo_rd_en && !app_en) begin
        checks++;
        if (app_wdf_data !== cur_wr.d1) begin
          errors++;
          $display("FAIL wr_beat2: got data=%h, required %h", app_wdf_data[31:0], cur_wr.d1[31:0]);
        end
        mem1[cur_addr] = app_wdf_data;
      end
      if (rst_n) pop = wr_fifo_rd_en;
      if (rd_data_valid) begin
        rd_beat_cnt++;
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got data=%h, required no beat", rd_data[31:0]);
        end else begin
          b0 = exp_rd_q.pop_front();
          if (rd_data !== b0) begin
            errors++;
            $display("FAIL rd_data: got %h, required %h", rd_data[31:0], b0[31:0]);
          end
          if (acc_rd) b0 = mem0.exists(app_addr) ? mem0[app_addr] : '0;
        end
      end
      if (wr_done) wr_done_cnt++;
      if (rd_done) begin
        rd_done_cnt++;
        beats_at_done = rd_beat_cnt;
      end
      @(posedge clk); #1;
      if (pop && fifo_q.size() != 0) begin
        void'(fifo_q.pop_front());
        pop_cnt++;
      end
      if (acc_rd) begin
        ret_q.push_back(b0);
        ret_q.push_back(b1);
      end
      if (inject) begin
        app_rd_data_valid = 1'b1; app_rd_data = inject_data; inject = 1'b0;
      end else if (ret_q.size() != 0) begin
        app_rd_data_valid = 1'b1; app_rd_data = ret_q.pop_front();
      end else begin
        app_rd_data_valid = 1'b0;
      end
      fifo_refresh();
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({app_en, wr_fifo_rd_en, wr_busy, wr_done, rd_busy, rd_done, rd_data_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {app_en, wr_fifo_rd_en, wr_busy, wr_done, rd_busy, rd_done, rd_data_valid});
    end
    checks++;
    if (app_cmd !== 3'b001) begin errors++; $display("FAIL reset_cmd: got %b, required 001", app_cmd); end
    checks++;
    if (app_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h, required 0", app_addr); end
    checks++;
    if (app_wdf_data !== '0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got wdf=%h rd=%h, required 0", app_wdf_data[31:0], rd_data[31:0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_init_gate();
    for (int j = 0; j < 4; j++) fifo_q.push_back(pat(j));
    fifo_refresh();
    push_cmd(CMD_WR, 29'h100, pat(0), pat(1));
    push_cmd(CMD_WR, 29'h108, pat(2), pat(3));
    start_wr(29'h100, 16'd2);
    en_cnt = 0;
    repeat (1000) @(negedge clk);
    checks++;
    if (en_cnt !== 0 || wr_busy !== 1'b1) begin
      errors++;
      $display("FAIL init_gate: got app_en cycles=%0d busy=%b, required 0 and 1", en_cnt, wr_busy);
    end
    @(posedge clk); #1;
    phy_init_done = 1'b1;
    for (int i = 0; i < 200 && wr_done_cnt < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_done_cnt !== 1 || pop_cnt !== 4 || exp_cmd_q.size() !== 0 || wr_busy !== 1'b0) begin
      errors++;
      $display("FAIL init_write: got done=%0d pops=%0d left=%0d busy=%b, required 1 4 0 0",
               wr_done_cnt, pop_cnt, exp_cmd_q.size(), wr_busy);
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    int                waited;
    clear_models();
    @(posedge clk); #1;
    app_rdy = 1'b0;
    fifo_q.push_back(pat(10)); fifo_q.push_back(pat(11));
    fifo_refresh();
    push_cmd(CMD_WR, 29'h180, pat(10), pat(11));
    start_wr(29'h180, 16'd1);
    waited = 0;
    while (!app_en && waited < 50) begin @(negedge clk); waited++; end
    a0 = app_addr; d0 = app_wdf_data;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!app_en || app_addr !== a0 || app_wdf_data !== d0 || wr_fifo_rd_en !== 1'b0 || a0 !== 29'h180) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got en=%b addr=%h pop=%b, required en=1 addr=180 pop=0",
                 i, app_en, app_addr, wr_fifo_rd_en);
      end
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    app_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_fifo_rd_en !== 1'b1) begin errors++; $display("FAIL bp_release_pop: got %b, required 1", wr_fifo_rd_en); end
    for (int i = 0; i < 50 && wr_done_cnt < 1; i++) @(negedge clk);
    checks++;
    if (wr_done_cnt !== 1 || pop_cnt !== 2) begin
      errors++;
      $display("FAIL bp_done: got done=%0d pops=%0d, required 1 2", wr_done_cnt, pop_cnt);
    end
  endtask

  task automatic test_read_loopback();
    clear_models();
    for (int j = 20; j < 28; j++) fifo_q.push_back(pat(j));
    fifo_refresh();
    for (int k = 0; k < 4; k++) push_cmd(CMD_WR, 29'(29'h200 + 8 * k), pat(20 + 2 * k), pat(21 + 2 * k));
    start_wr(29'h200, 16'd4);
    for (int i = 0; i < 200 && wr_done_cnt < 1; i++) @(negedge clk);
    checks++;
    if (wr_done_cnt !== 1) begin errors++; $display("FAIL loop_wr_done: got %0d, required 1", wr_done_cnt); end
    for (int k = 0; k < 4; k++) push_cmd(CMD_RD, 29'(29'h200 + 8 * k), '0, '0);
    for (int j = 20; j < 28; j++) exp_rd_q.push_back(pat(j));
    start_rd(29'h200, 16'd4);
    for (int i = 0; i < 300 && rd_done_cnt < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (rd_done_cnt !== 1 || beats_at_done !== 8 || rd_beat_cnt !== 8) begin
      errors++;
      $display("FAIL loop_rd_done: got done=%0d at_beat=%0d beats=%0d, required 1 8 8",
               rd_done_cnt, beats_at_done, rd_beat_cnt);
    end
    checks++;
    if (rd_busy !== 1'b0 || exp_rd_q.size() !== 0 || exp_cmd_q.size() !== 0) begin
      errors++;
      $display("FAIL loop_idle: got busy=%b rd_left=%0d cmd_left=%0d, required 0 0 0",
               rd_busy, exp_rd_q.size(), exp_cmd_q.size());
    end
  endtask

  task automatic test_interleave();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    clear_models();
    rst_n = 1'b1;
    for (int j = 30; j < 36; j++) fifo_q.push_back(pat(j));
    fifo_refresh();
    for (int k = 0; k < 3; k++) begin
      push_cmd(CMD_WR, 29'(29'h400 + 8 * k), pat(30 + 2 * k), pat(31 + 2 * k));
      push_cmd(CMD_RD, 29'(29'h200 + 8 * k), '0, '0);
      exp_rd_q.push_back(pat(20 + 2 * k));
      exp_rd_q.push_back(pat(21 + 2 * k));
    end
    @(posedge clk); #1;
    wr_addr = 29'h400; wr_len = 16'd3; wr_start = 1'b1;
    rd_addr = 29'h200; rd_len = 16'd3; rd_start = 1'b1;
    @(posedge clk); #1;
    wr_start = 1'b0; rd_start = 1'b0;
    for (int i = 0; i < 400 && (wr_done_cnt < 1 || rd_done_cnt < 1); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_done_cnt !== 1 || rd_done_cnt !== 1 || exp_cmd_q.size() !== 0 || exp_rd_q.size() !== 0) begin
      errors++;
      $display("FAIL interleave: got wr_done=%0d rd_done=%0d cmd_left=%0d rd_left=%0d, required 1 1 0 0",
               wr_done_cnt, rd_done_cnt, exp_cmd_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic test_edges();
    clear_models();
    en_cnt = 0;
    @(posedge clk); #1;
    wr_len = '0; rd_len = '0; wr_start = 1'b1; rd_start = 1'b1;
    @(posedge clk); #1;
    wr_start = 1'b0; rd_start = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (wr_busy !== 1'b0 || rd_busy !== 1'b0 || en_cnt !== 0) begin
      errors++;
      $display("FAIL len_zero: got wr_busy=%b rd_busy=%b en=%0d, required 0 0 0", wr_busy, rd_busy, en_cnt);
    end
    for (int j = 40; j < 44; j++) fifo_q.push_back(pat(j));
    fifo_refresh();
    push_cmd(CMD_WR, 29'h1FFF_FFF8, pat(40), pat(41));
    push_cmd(CMD_WR, 29'h0, pat(42), pat(43));
    start_wr(29'h1FFF_FFF8, 16'd2);
    for (int i = 0; i < 100 && wr_done_cnt < 1; i++) @(negedge clk);
    checks++;
    if (wr_done_cnt !== 1 || exp_cmd_q.size() !== 0) begin
      errors++;
      $display("FAIL addr_wrap: got done=%0d cmd_left=%0d, required 1 0", wr_done_cnt, exp_cmd_q.size());
    end
    inject_data = pat(50);
    exp_rd_q.push_back(pat(50));
    @(posedge clk); #1;
    inject = 1'b1;
    for (int i = 0; i < 10 && rd_beat_cnt < 1; i++) @(negedge clk);
    checks++;
    if (rd_beat_cnt !== 1 || dut.u_rd_tracker.r_err_unexp !== 1'b1 || rd_done_cnt !== 0) begin
      errors++;
      $display("FAIL unexp_beat: got beats=%0d err=%b done=%0d, required 1 1 0",
               rd_beat_cnt, dut.u_rd_tracker.r_err_unexp, rd_done_cnt);
    end
  endtask

  task automatic test_reset_mid_job();
    int waited;
    clear_models();
    for (int j = 60; j < 64; j++) fifo_q.push_back(pat(j));
    fifo_refresh();
    push_cmd(CMD_WR, 29'h500, pat(60), pat(61));
    push_cmd(CMD_WR, 29'h508, pat(62), pat(63));
    start_wr(29'h500, 16'd2);
    waited = 0;
    while (!(wr_fifo_rd_en && !app_en) && waited < 50) begin @(negedge clk); waited++; end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({app_en, wr_fifo_rd_en, wr_busy, wr_done, rd_busy, rd_done, rd_data_valid} !== 7'b0 ||
        app_cmd !== 3'b001 || app_addr !== '0 || app_wdf_data !== '0 || waited >= 50) begin
      errors++;
      $display("FAIL reset_mid: got en=%b pop=%b busy=%b cmd=%b wdf=%h waited=%0d, required 0 0 0 001 0 <50",
               app_en, wr_fifo_rd_en, wr_busy, app_cmd, app_wdf_data[31:0], waited);
    end
    repeat (3) @(posedge clk);
    #2;
    clear_models();
    rst_n = 1'b1;
    fifo_q.push_back(pat(70)); fifo_q.push_back(pat(71));
    fifo_refresh();
    push_cmd(CMD_WR, 29'h600, pat(70), pat(71));
    start_wr(29'h600, 16'd1);
    for (int i = 0; i < 100 && wr_done_cnt < 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (wr_done_cnt !== 1 || exp_cmd_q.size() !== 0 || wr_busy !== 1'b0 || pop_cnt !== 2) begin
      errors++;
      $display("FAIL after_reset_job: got done=%0d cmd_left=%0d busy=%b pops=%0d, required 1 0 0 2",
               wr_done_cnt, exp_cmd_q.size(), wr_busy, pop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_init_gate();
    test_backpressure();
    test_read_loopback();
    test_interleave();
    test_edges();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr_burst_master.md
Name: ddr_burst_master

Overview:
Upstream command generator for the DDR app interface (2:1 mode; each command moves two 256-bit beats). Accepts block write jobs, fed from a show-ahead write FIFO, and block read jobs from the user side. Arbitrates between them after PHY init, drives app_en/cmd/addr/data, and returns read beats and done pulses. Sits between the frame/DMA logic and the DDR controller or simulation memory.

Parameters:
ADDR_W, 29, app address width
DATA_W, 256, app data width per beat
LEN_W, 16, job length width, in commands
ADDR_STEP, 8, app address increment per command
INIT_TO, 0, init-wait timeout in cycles; 0 means wait forever

Ports:
clk  in  1  controller clock
rst_n  in  1  asynchronous active-low reset
phy_init_done  in  1  DDR calibration complete
wr_start  in  1  pulse: launch write job
wr_addr  in  ADDR_W  write job start address
wr_len  in  LEN_W  write job length in commands; 0 is ignored
wr_fifo_rdata  in  DATA_W  show-ahead FIFO head
wr_fifo_cnt  in  10  FIFO occupancy in beats
wr_fifo_rd_en  out  1  pop one beat
wr_busy  out  1  write job active
wr_done  out  1  1-cycle pulse, last write command accepted
rd_start  in  1  pulse: launch read job
rd_addr  in  ADDR_W  read job start address
rd_len  in  LEN_W  read length in commands; 0 is ignored
rd_busy  out  1  read job active, including the data drain
rd_done  out  1  1-cycle pulse, last read beat delivered
rd_data  out  DATA_W  read beat
rd_data_valid  out  1  rd_data valid
app_en  out  1  command strobe
app_cmd  out  3  3'b000 is write, 3'b001 is read
app_addr  out  ADDR_W  command address
app_wdf_data  out  DATA_W  write beat
app_rdy  in  1  controller accepts command
app_wdf_rdy  in  1  controller accepts write data
app_rd_data  in  DATA_W  controller read data
app_rd_data_valid  in  1  controller read data valid

Behaviour:
- Reset: every output 0, except app_cmd, which resets to 3'b001. FSM goes to WAIT_INIT. Job registers and counters clear.
- Job launch: wr_start is latched only while wr_busy=0 and wr_len!=0, otherwise dropped. The same rule applies to rd_start/rd_busy/rd_len. Busy goes high the cycle after the start pulse. Address and length are captured at launch.
- FSM states: WAIT_INIT, ARB, WR_CMD, WR_BEAT2, RD_CMD, RD_GAP.
- WAIT_INIT -> ARB when phy_init_done=1. This is sticky: later deassertion is ignored.
- ARB with a single pending job: go to that job's state. With both pending: round-robin, favouring the type not served last; write wins after reset.
- ARB only enters WR_CMD when wr_fifo_cnt>=2.
- WR_CMD: drive app_en=1, app_cmd=000, app_addr=cur_wr_addr, app_wdf_data=FIFO head, and wr_fifo_rd_en=1. Everything is held until app_rdy&app_wdf_rdy; pop happens only on that acceptance cycle.
- WR_BEAT2: app_en=0, drive the second FIFO beat, pop it when app_wdf_rdy=1. Then:
  - decrement the length and add ADDR_STEP to the address (modulo 2^ADDR_W, wraps silently);
  - if length reaches 0, pulse wr_done, clear wr_busy, go to ARB;
  - otherwise return to ARB to re-arbitrate, giving command-level interleave.
- RD_CMD: app_en=1, app_cmd=001, app_addr=cur_rd_addr, held until app_rdy. RD_GAP is one idle cycle, then the length/address update as for writes, then ARB.
- Read return:
  - rd_data/rd_data_valid are registered copies of app_rd_data/app_rd_data_valid, with 1-cycle latency.
  - An outstanding-beat counter adds 2 per accepted read command and subtracts 1 per valid beat.
  - rd_done pulses and rd_busy clears when all commands are issued and the counter reaches 0.
  - A valid beat arriving with no beats outstanding is still forwarded, and the sticky status bit err_unexp sets. err_unexp is internal, observable by hierarchy.
- Simultaneous events: a start arriving on the same cycle its own job's done pulses is dropped, because busy is still 1.
- Reset mid-job: the job is abandoned and all outputs return to reset values asynchronously.
- INIT_TO>0 and phy_init_done still low after INIT_TO cycles: the FSM stays in WAIT_INIT, and the internal sticky bit init_timeout sets.

Decomposition:
- Package ddr_mst_pkg contains:
  - CMD_WR=3'b000 and CMD_RD=3'b001;
  - the state enum;
  - BEATS_PER_CMD=2.
- Sub-module ddr_rd_tracker holds the outstanding-beat counter, the done detection and the read-data register stage.

Test Plan:
- Init gate: wr_start with addr=0x100, len=2, and 4 beats in the FIFO while phy_init_done=0 for 1000 cycles -> no app_en. Then two commands at 0x100 and 0x108, 4 pops, and a wr_done pulse.
- Backpressure: during WR_CMD, app_rdy=0 for 5 cycles -> app_en/addr/data held stable, no pop. The pop occurs on the release cycle.
- Read loopback: after writing pattern i at 0x200 len=4, read at 0x200 len=4 -> 8 rd_data_valid beats, data equal to the pattern in order, one rd_done after the 8th beat.
- Interleave: both jobs pending (len 3 each) -> command order W,R,W,R,W,R.
- Edge cases: len=0 start is ignored, busy stays 0. Addr 0x1FFFFFF8 with len=2 -> second command at 0x0.
- Reset mid-job: rst_n asserted during WR_BEAT2 -> all outputs are 0 immediately. A new job after release completes normally.
